// File: rtl/cpu_writeback_unit_if.sv
// Bus between the memory unit / decode stage and the writeback unit.
// Carries the MEM result path, the decode read ports and the forwarding outputs.
// Valid/ready semantics: there is no ready; a result is consumed on every rising
// clock edge where i_pipeline_enable=1, and WB never back-pressures MEM.
interface cpu_writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            i_pipeline_enable;
  logic            i_flush;
  logic [4:0]      i_rd;
  logic [XLEN-1:0] i_rd_data;
  logic [4:0]      i_rs1_addr;
  logic [4:0]      i_rs2_addr;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic            o_fwd_valid;
  logic [4:0]      o_fwd_rd;
  logic [XLEN-1:0] o_fwd_data;
  logic [63:0]     o_retire_count;

  // Upstream side: memory unit and decode stage
  modport master (
    output i_pipeline_enable, i_flush, i_rd, i_rd_data, i_rs1_addr, i_rs2_addr,
    input  o_rs1_data, o_rs2_data, o_fwd_valid, o_fwd_rd, o_fwd_data, o_retire_count
  );

  // Writeback unit side
  modport slave (
    input  i_pipeline_enable, i_flush, i_rd, i_rd_data, i_rs1_addr, i_rs2_addr,
    output o_rs1_data, o_rs2_data, o_fwd_valid, o_fwd_rd, o_fwd_data, o_retire_count
  );
endinterface

// File: rtl/cpu_writeback_unit.sv
// WB stage of the 5-stage RISC-V pipeline: MEM/WB staging register, the
// 32-entry integer register file with write-first bypass on both decode read
// ports, and a forwarding export of the staged result.
// Optional macro WB_RETIRE_COUNT_EN adds a 64-bit retired-instruction counter;
// without it o_retire_count is tied to zero.
module cpu_writeback_unit #(
  parameter int XLEN          = 32,
  parameter bit RESET_REGFILE = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  cpu_writeback_unit_if.slave  bus
);

  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic [XLEN-1:0] r_regs [1:31];

  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [63:0]     w_retire_count;

  // MEM/WB staging: a stalled MEM (enable=0) inserts a bubble so the held
  // result is never committed twice; rd=0 and flushed instructions never stage valid.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else if (bus.i_pipeline_enable) begin
      r_wb_valid <= (bus.i_rd != 5'd0) && !bus.i_flush;
      r_wb_rd    <= bus.i_rd;
      r_wb_data  <= bus.i_rd_data;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  // Register file commit from the pre-edge staged value; x0 has no storage.
  generate
    if (RESET_REGFILE) begin : g_regfile_rst
      // Commit with all architectural registers cleared on reset
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          for (int i = 1; i < 32; i++) r_regs[i] <= '0;
        end else begin
          for (int i = 1; i < 32; i++) begin
            if (r_wb_valid && (r_wb_rd == 5'(i))) r_regs[i] <= r_wb_data;
          end
        end
      end
    end else begin : g_regfile_norst
      // Commit without reset; a staged write is dropped by r_wb_valid clearing
      always_ff @(posedge i_clk) begin
        for (int i = 1; i < 32; i++) begin
          if (r_wb_valid && (r_wb_rd == 5'(i))) r_regs[i] <= r_wb_data;
        end
      end
    end
  endgenerate

  // Read port 1: x0 -> 0, staged result wins over the register file
  always_comb begin
    w_rs1_data = '0;
    if (bus.i_rs1_addr != 5'd0) begin
      if (r_wb_valid && (bus.i_rs1_addr == r_wb_rd)) begin
        w_rs1_data = r_wb_data;
      end else begin
        for (int i = 1; i < 32; i++) begin
          if (bus.i_rs1_addr == 5'(i)) w_rs1_data = r_regs[i];
        end
      end
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    w_rs2_data = '0;
    if (bus.i_rs2_addr != 5'd0) begin
      if (r_wb_valid && (bus.i_rs2_addr == r_wb_rd)) begin
        w_rs2_data = r_wb_data;
      end else begin
        for (int i = 1; i < 32; i++) begin
          if (bus.i_rs2_addr == 5'(i)) w_rs2_data = r_regs[i];
        end
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] r_retire_count;

  // Count every instruction leaving MEM unflushed, including stores and rd=0
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_retire_count <= '0;
    end else if (bus.i_pipeline_enable && !bus.i_flush) begin
      r_retire_count <= r_retire_count + 64'd1;
    end
  end

  assign w_retire_count = r_retire_count;
`else
  assign w_retire_count = '0;
`endif

  assign bus.o_rs1_data     = w_rs1_data;
  assign bus.o_rs2_data     = w_rs2_data;
  assign bus.o_fwd_valid    = r_wb_valid;
  assign bus.o_fwd_rd       = r_wb_rd;
  assign bus.o_fwd_data     = r_wb_data;
  assign bus.o_retire_count = w_retire_count;

endmodule

// File: tb/tb_cpu_writeback_unit.sv
// Bench for cpu_writeback_unit: directed vector table, reset sequences and a
// randomized phase compared against an architectural register model.
module tb_cpu_writeback_unit;

  localparam int XLEN = 32;

  logic i_clk;
  logic i_reset_n;

  cpu_writeback_unit_if #(.XLEN(XLEN)) bus ();

  cpu_writeback_unit #(.XLEN(XLEN), .RESET_REGFILE(1'b1)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus.slave)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Architectural view: a register reads as the latest accepted write to it,
  // whether or not that write has reached the register file yet.
  logic [XLEN-1:0] m_arch [32];
  logic            m_fwd_valid;
  logic [4:0]      m_fwd_rd;
  logic [XLEN-1:0] m_fwd_data;
  logic [63:0]     m_retired;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_arch[i] = '0;
    m_fwd_valid = 1'b0;
    m_fwd_rd    = '0;
    m_fwd_data  = '0;
    m_retired   = '0;
  endtask

  task automatic model_edge(input logic en, input logic fl, input logic [4:0] rd,
                            input logic [XLEN-1:0] data);
    if (en) begin
      m_fwd_rd    = rd;
      m_fwd_data  = data;
      m_fwd_valid = (rd != 0) && !fl;
      if ((rd != 0) && !fl) m_arch[rd] = data;
      if (!fl) m_retired = m_retired + 64'd1;
    end else begin
      m_fwd_valid = 1'b0;
    end
  endtask

  function automatic logic [63:0] exp_retire();
`ifdef WB_RETIRE_COUNT_EN
    return m_retired;
`else
    return 64'd0;
`endif
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model_outputs();
    chk("fwd_valid", 64'(bus.o_fwd_valid), 64'(m_fwd_valid));
    chk("fwd_rd", 64'(bus.o_fwd_rd), 64'(m_fwd_rd));
    chk("fwd_data", 64'(bus.o_fwd_data), 64'(m_fwd_data));
    chk("retire_count", bus.o_retire_count, exp_retire());
  endtask

  task automatic chk_reads(input logic [4:0] a1, input logic [4:0] a2);
    bus.i_rs1_addr = a1;
    bus.i_rs2_addr = a2;
    #1;
    chk("rs1_model", 64'(bus.o_rs1_data), 64'(m_arch[a1]));
    chk("rs2_model", 64'(bus.o_rs2_data), 64'(m_arch[a2]));
  endtask

  // ---------------- driver ----------------
  // One clock: present MEM inputs, take the edge, then check staging and reads.
  task automatic step(input logic en, input logic fl, input logic [4:0] rd,
                      input logic [XLEN-1:0] data, input logic [4:0] a1,
                      input logic [4:0] a2);
    bus.i_pipeline_enable = en;
    bus.i_flush           = fl;
    bus.i_rd              = rd;
    bus.i_rd_data         = data;
    @(posedge i_clk);
    model_edge(en, fl, rd, data);
    #1;
    chk_model_outputs();
    chk_reads(a1, a2);
  endtask

  task automatic apply_reset();
    bus.i_pipeline_enable = 1'b0;
    bus.i_flush           = 1'b0;
    bus.i_rd              = '0;
    bus.i_rd_data         = '0;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    chk("reset_fwd_valid", 64'(bus.o_fwd_valid), 64'd0);
    chk("reset_fwd_rd", 64'(bus.o_fwd_rd), 64'd0);
    chk("reset_fwd_data", 64'(bus.o_fwd_data), 64'd0);
    chk("reset_retire", bus.o_retire_count, 64'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            en;
    logic            fl;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [4:0]      a1;
    logic [4:0]      a2;
    logic [XLEN-1:0] exp_rs1;
    logic [XLEN-1:0] exp_rs2;
    logic            exp_fv;
    logic [63:0]     exp_cnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    //          en    fl    rd     data          a1     a2     rs1           rs2           fv    cnt
    vecs[0]  = '{1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b1, 64'd1};
    vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 64'd1};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h12345678, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 64'd2};
    vecs[3]  = '{1'b1, 1'b0, 5'd7, 32'h1,        5'd5, 5'd7, 32'hDEADBEEF, 32'h1,        1'b1, 64'd3};
    vecs[4]  = '{1'b1, 1'b0, 5'd7, 32'h2,        5'd7, 5'd7, 32'h2,        32'h2,        1'b1, 64'd4};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'h2,        32'h2,        1'b0, 64'd4};
    vecs[6]  = '{1'b1, 1'b0, 5'd9, 32'hA,        5'd9, 5'd7, 32'hA,        32'h2,        1'b1, 64'd5};
    vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 32'hA,        32'hA,        1'b0, 64'd5};
    vecs[8]  = '{1'b1, 1'b1, 5'd3, 32'h55,       5'd3, 5'd9, 32'h0,        32'hA,        1'b0, 64'd5};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 32'h0,        32'hA,        1'b0, 64'd5};
    vecs[10] = '{1'b1, 1'b0, 5'd3, 32'h66,       5'd3, 5'd5, 32'h66,       32'hDEADBEEF, 1'b1, 64'd6};
    vecs[11] = '{1'b1, 1'b1, 5'd3, 32'h77,       5'd3, 5'd9, 32'h66,       32'hA,        1'b0, 64'd6};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] cnt_exp;
    bus.i_rs1_addr = '0;
    bus.i_rs2_addr = '0;
    i_reset_n = 1'b1;
    #2;
    apply_reset();

    // All 32 addresses read zero after reset on both ports
    for (int a = 0; a < 32; a++) begin
      bus.i_rs1_addr = 5'(a);
      bus.i_rs2_addr = 5'(31 - a);
      #1;
      chk("post_reset_rs1", 64'(bus.o_rs1_data), 64'd0);
      chk("post_reset_rs2", 64'(bus.o_rs2_data), 64'd0);
    end

    // Reset arriving while a write to x5 is staged discards it
    step(1'b1, 1'b0, 5'd5, 32'h0000_1234, 5'd5, 5'd1);
    chk("staged_x5_bypass", 64'(bus.o_rs1_data), 64'h1234);
    #1;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_fwd_valid", 64'(bus.o_fwd_valid), 64'd0);
    bus.i_pipeline_enable = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("x5_after_reset", 64'(bus.o_rs1_data), 64'd0);

    // Directed table from a clean reset
    apply_reset();
    for (int v = 0; v < 12; v++) begin
      step(vecs[v].en, vecs[v].fl, vecs[v].rd, vecs[v].data, vecs[v].a1, vecs[v].a2);
      chk($sformatf("vec%0d_rs1", v), 64'(bus.o_rs1_data), 64'(vecs[v].exp_rs1));
      chk($sformatf("vec%0d_rs2", v), 64'(bus.o_rs2_data), 64'(vecs[v].exp_rs2));
      chk($sformatf("vec%0d_fwd_valid", v), 64'(bus.o_fwd_valid), 64'(vecs[v].exp_fv));
`ifdef WB_RETIRE_COUNT_EN
      cnt_exp = vecs[v].exp_cnt;
`else
      cnt_exp = 64'd0;
`endif
      chk($sformatf("vec%0d_retire", v), bus.o_retire_count, cnt_exp);
    end

    // Randomized traffic, destinations biased to a few registers for hazards
    for (int c = 0; c < 600; c++) begin
      logic            en, fl;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      en   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 6) == 0);
      rd   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      data = $urandom;
      step(en, fl, rd, data, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31)));
    end

    // Full register sweep against the model after random traffic
    bus.i_pipeline_enable = 1'b0;
    @(posedge i_clk);
    model_edge(1'b0, 1'b0, 5'd0, '0);
    #1;
    for (int a = 0; a < 32; a++) chk_reads(5'(a), 5'(a));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total runtime
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
